game_round_controller: RTL and testbench

Parametrised N-player game-round controller, the successor of the two-player password/load/add datapath. It gates player entry behind a password and captures one DATA_W value per player per round through player buttons. Once every player has loaded, it produces a registered sum and holds it until the next round. It sits between the button shapers, which deliver one-cycle pulses, and the seven-segment decoders, which stay outside this block.

---
 rtl/game_pkg.sv | 18 +
 rtl/player_slot.sv | 29 ++
 rtl/game_round_controller.sv | 182 ++++++++++++++++++
 tb/tb_game_round_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the N-player game-round controller.
// Provides the FSM state encoding and the width rule for the player-value sum.
package game_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_SUM     = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKOUT = 3'd4
    } game_state_t;

    // Wide enough that N full-scale values never overflow the sum.
    function automatic int sum_width(input int n_players, input int data_w);
        return data_w + $clog2(n_players);
    endfunction

endpackage

// File: rtl/player_slot.sv
// One player channel: a captured value and a per-round loaded flag.
// A load is accepted only once per round; clear drops the flag but keeps the value.
module player_slot
    import game_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] value,
    output logic              loaded
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value  <= '0;
            loaded <= 1'b0;
        end else if (clear) begin
            loaded <= 1'b0;
        end else if (load && !loaded) begin
            value  <= din;
            loaded <= 1'b1;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Password-gated N-player round controller: captures one value per player and registers their sum.
// Define GAME_LOCKOUT_EN to add the wrong-password try counter and timed lockout.
module game_round_controller
    import game_pkg::*;
#(
    parameter int                N_PLAYERS      = 2,
    parameter int                DATA_W         = 4,
    parameter int                PW_W           = 4,
    parameter logic [PW_W-1:0]   PASSWORD       = 4'hB,
    parameter int                MAX_TRIES      = 3,
    parameter int                LOCKOUT_CYCLES = 8
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      password_button,
    input  logic [PW_W-1:0]                           password,
    input  logic [N_PLAYERS-1:0]                      player_button,
    input  logic [N_PLAYERS*DATA_W-1:0]               player_in,
    output logic [N_PLAYERS*DATA_W-1:0]               player_value,
    output logic [N_PLAYERS-1:0]                      player_loaded,
    output logic [sum_width(N_PLAYERS, DATA_W)-1:0]   sum,
    output logic                                      sum_valid,
    output logic                                      red_LED,
    output logic                                      green_LED,
    output logic                                      locked_out
);

    localparam int SUM_W = sum_width(N_PLAYERS, DATA_W);

    if (N_PLAYERS < 2 || MAX_TRIES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
        $error("game_round_controller: invalid parameter set");
    end

    game_state_t        state_reg;
    game_state_t        state_next;
    logic               pw_ok;
    logic               all_loaded;
    logic               round_clear;
    logic [SUM_W-1:0]   sum_next;

    assign pw_ok       = password_button && (password == PASSWORD);
    assign all_loaded  = &player_loaded;
    assign round_clear = (state_reg == ST_DONE) && password_button;

`ifdef GAME_LOCKOUT_EN
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [TRY_W-1:0]  try_cnt_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              pw_bad;
    logic              lockout_hit;

    assign pw_bad      = password_button && (password != PASSWORD);
    assign lockout_hit = (state_reg == ST_LOCKED) && pw_bad
                         && (try_cnt_reg == TRY_W'(MAX_TRIES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            try_cnt_reg  <= '0;
            lock_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_LOCKED && pw_ok) begin
                try_cnt_reg <= '0;
            end else if (state_reg == ST_LOCKED && pw_bad) begin
                try_cnt_reg <= try_cnt_reg + 1'b1;
            end else if (state_reg == ST_LOCKOUT && lock_cnt_reg == '0) begin
                try_cnt_reg <= '0;
            end

            // Loading on entry makes the lockout last exactly LOCKOUT_CYCLES cycles.
            if (lockout_hit) begin
                lock_cnt_reg <= LOCK_W'(LOCKOUT_CYCLES - 1);
            end else if (state_reg == ST_LOCKOUT && lock_cnt_reg != '0) begin
                lock_cnt_reg <= lock_cnt_reg - 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_LOCKED;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOCKED: begin
                if (pw_ok) begin
                    state_next = ST_ENTRY;
`ifdef GAME_LOCKOUT_EN
                end else if (lockout_hit) begin
                    state_next = ST_LOCKOUT;
`endif
                end
            end
            ST_ENTRY: begin
                if (all_loaded) begin
                    state_next = ST_SUM;
                end
            end
            ST_SUM: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (password_button) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
`ifdef GAME_LOCKOUT_EN
                if (lock_cnt_reg == '0) begin
                    state_next = ST_LOCKED;
                end
`else
                state_next = ST_LOCKED;
`endif
            end
            default: begin
                state_next = ST_LOCKED;
            end
        endcase
    end

    always_comb begin
        red_LED    = 1'b0;
        green_LED  = 1'b0;
        locked_out = 1'b0;
        case (state_reg)
            ST_LOCKED:  red_LED   = 1'b1;
            ST_ENTRY:   green_LED = 1'b1;
            ST_SUM:     green_LED = 1'b1;
            ST_DONE:    green_LED = 1'b1;
            ST_LOCKOUT: begin
                red_LED    = 1'b1;
`ifdef GAME_LOCKOUT_EN
                locked_out = 1'b1;
`endif
            end
            default:    red_LED   = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_slot
        player_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clock  (clock),
            .reset  (reset),
            .load   ((state_reg == ST_ENTRY) && player_button[gi]),
            .clear  (round_clear),
            .din    (player_in[gi*DATA_W +: DATA_W]),
            .value  (player_value[gi*DATA_W +: DATA_W]),
            .loaded (player_loaded[gi])
        );
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            sum_next = sum_next + SUM_W'(player_value[i*DATA_W +: DATA_W]);
        end
    end

    // The sum is kept across rounds; only its valid flag is dropped on a new round.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else if (state_reg == ST_SUM) begin
            sum       <= sum_next;
            sum_valid <= 1'b1;
        end else if (round_clear) begin
            sum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed test of game_round_controller with N_PLAYERS=2, DATA_W=4, PASSWORD=4'hB.
// Lockout scenarios run when GAME_LOCKOUT_EN is defined, the no-lockout scenario otherwise.
module tb_game_round_controller;

    logic       clock;
    logic       reset;
    logic       password_button;
    logic [3:0] password;
    logic [1:0] player_button;
    logic [7:0] player_in;
    logic [7:0] player_value;
    logic [1:0] player_loaded;
    logic [4:0] sum;
    logic       sum_valid;
    logic       red_LED;
    logic       green_LED;
    logic       locked_out;

    int n_pass  = 0;
    int n_total = 0;

    game_round_controller #(
        .N_PLAYERS      (2),
        .DATA_W         (4),
        .PW_W           (4),
        .PASSWORD       (4'hB),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .password_button (password_button),
        .password        (password),
        .player_button   (player_button),
        .player_in       (player_in),
        .player_value    (player_value),
        .player_loaded   (player_loaded),
        .sum             (sum),
        .sum_valid       (sum_valid),
        .red_LED         (red_LED),
        .green_LED       (green_LED),
        .locked_out      (locked_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_red"},    32'(red_LED),       32'd1);
        check({tag, "_green"},  32'(green_LED),     32'd0);
        check({tag, "_lock"},   32'(locked_out),    32'd0);
        check({tag, "_pv"},     32'(player_value),  32'h00);
        check({tag, "_pl"},     32'(player_loaded), 32'd0);
        check({tag, "_sum"},    32'(sum),           32'd0);
        check({tag, "_sv"},     32'(sum_valid),     32'd0);
    endtask

    // Called at a negedge; applies a one-cycle pulse and returns at the next negedge.
    task automatic press_pw(input logic [3:0] pw);
        password        = pw;
        password_button = 1'b1;
        @(negedge clock);
        password_button = 1'b0;
    endtask

    task automatic press_pl(input logic [1:0] mask, input logic [3:0] v0, input logic [3:0] v1);
        player_in     = {v1, v0};
        player_button = mask;
        @(negedge clock);
        player_button = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset           = 1'b1;
        password_button = 1'b0;
        password        = 4'h0;
        player_button   = 2'b00;
        player_in       = 8'h00;
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        $display("txn: reset released");

        // Scenario 1: correct password grants entry
        press_pw(4'hB);
        $display("txn: password 0xB");
        check("s1_green", 32'(green_LED), 32'd1);
        check("s1_red",   32'(red_LED),   32'd0);

        // Scenario 2: sequential loads and 2-cycle sum latency
        press_pl(2'b01, 4'h9, 4'h0);
        $display("txn: p0 loads 0x9");
        check("s2_pv_p0", 32'(player_value[3:0]), 32'h9);
        check("s2_pl_p0", 32'(player_loaded),     32'b01);
        press_pl(2'b10, 4'h0, 4'hF);
        $display("txn: p1 loads 0xF");
        check("s2_pl_all", 32'(player_loaded), 32'b11);
        check("s2_sv_k0",  32'(sum_valid),     32'd0);
        idle(1);
        check("s2_sv_k1",  32'(sum_valid),     32'd0);
        idle(1);
        check("s2_sv_k2",  32'(sum_valid),     32'd1);
        check("s2_sum",    32'(sum),           32'd24);
        check("s2_green",  32'(green_LED),     32'd1);
        press_pl(2'b11, 4'h1, 4'h1);
        $display("txn: player press in DONE");
        check("s2_done_pv",  32'(player_value), 32'hF9);
        check("s2_done_sum", 32'(sum),          32'd24);
        press_pw(4'h0);
        $display("txn: password press in DONE");
        check("s2_new_red", 32'(red_LED),       32'd1);
        check("s2_new_pl",  32'(player_loaded), 32'd0);
        check("s2_new_sv",  32'(sum_valid),     32'd0);
        check("s2_new_sum", 32'(sum),           32'd24);
        check("s2_new_pv",  32'(player_value),  32'hF9);

        // Scenario 3: ignored presses, repeated press, simultaneous press
        press_pl(2'b01, 4'h5, 4'h0);
        $display("txn: player press in LOCKED");
        check("s3_lk_pl", 32'(player_loaded), 32'd0);
        check("s3_lk_pv", 32'(player_value),  32'hF9);
        press_pw(4'hB);
        press_pl(2'b01, 4'h3, 4'h0);
        $display("txn: p0 loads 0x3");
        press_pl(2'b01, 4'h7, 4'h0);
        $display("txn: p0 presses again with 0x7");
        check("s3_rep_pv", 32'(player_value[3:0]), 32'h3);
        check("s3_rep_pl", 32'(player_loaded),     32'b01);
        press_pw(4'h0);
        $display("txn: password press in ENTRY");
        check("s3_pw_green", 32'(green_LED),     32'd1);
        check("s3_pw_pl",    32'(player_loaded), 32'b01);
        press_pl(2'b10, 4'h0, 4'h4);
        idle(2);
        check("s3_sum7", 32'(sum), 32'd7);
        press_pw(4'h0);
        press_pw(4'hB);
        press_pl(2'b11, 4'h7, 4'h8);
        $display("txn: p0=0x7 and p1=0x8 simultaneously");
        check("s3_sim_pl", 32'(player_loaded), 32'b11);
        check("s3_sim_pv", 32'(player_value),  32'h87);
        idle(2);
        check("s3_sim_sv",  32'(sum_valid), 32'd1);
        check("s3_sim_sum", 32'(sum),       32'd15);

        // Scenario 5: asynchronous reset during DONE
        #2 reset = 1'b0;
        #1 check_reset_outputs("s5");
        $display("txn: reset asserted in DONE");
        @(negedge clock);
        reset = 1'b1;
        press_pl(2'b11, 4'h2, 4'h3);
        $display("txn: player press after reset");
        check("s5_pl",  32'(player_loaded), 32'd0);
        check("s5_pv",  32'(player_value),  32'h00);
        press_pw(4'hB);
        check("s5_green", 32'(green_LED), 32'd1);
        press_pl(2'b11, 4'h2, 4'h3);
        idle(2);
        check("s5_sum", 32'(sum), 32'd5);
        press_pw(4'h0);
        check("s5_red", 32'(red_LED), 32'd1);

`ifdef GAME_LOCKOUT_EN
        // Scenario 4: three wrong passwords cause an 8-cycle lockout
        press_pw(4'h0);
        press_pw(4'h0);
        $display("txn: two wrong passwords");
        check("s4_pre_lock", 32'(locked_out), 32'd0);
        check("s4_pre_red",  32'(red_LED),    32'd1);
        press_pw(4'h0);
        $display("txn: third wrong password");
        check("s4_lock_c1", 32'(locked_out), 32'd1);
        press_pw(4'hB);
        $display("txn: correct password during lockout");
        check("s4_lock_c2",  32'(locked_out), 32'd1);
        check("s4_lock_grn", 32'(green_LED),  32'd0);
        idle(6);
        check("s4_lock_c8", 32'(locked_out), 32'd1);
        idle(1);
        check("s4_unlock",     32'(locked_out), 32'd0);
        check("s4_unlock_red", 32'(red_LED),    32'd1);
        press_pw(4'h0);
        press_pw(4'h0);
        check("s4_tries_clr", 32'(locked_out), 32'd0);
        press_pw(4'hB);
        check("s4_reentry", 32'(green_LED), 32'd1);
`else
        // Scenario 6: without lockout, wrong passwords never lock out
        for (int i = 0; i < 5; i++) begin
            press_pw(4'h0);
            $display("txn: wrong password %0d", i + 1);
            check("s6_lock", 32'(locked_out), 32'd0);
            check("s6_red",  32'(red_LED),    32'd1);
        end
        press_pw(4'hB);
        $display("txn: correct password");
        check("s6_green", 32'(green_LED), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
